hilo_multdiv: RTL and testbench
===============================

HILO_MULTDIV -- requirements
Module: hilo_multdiv

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request qualifier for ALUctrl/operands; sampled on rising clk.
REQ-004 ALUctrl  input  6  operation code from the ALU controller: 0x13 = multiply unsigned; 0x14 = divide unsigned (only with REQ-026 macro); all other codes are not operations of this block.
REQ-005 op_a  input  32  multiplicand / dividend.
REQ-006 op_b  input  32  multiplier / divisor.
REQ-007 flush  input  1  abort of any in-flight operation.
REQ-008 busy  output  1  high while an operation iterates; pipeline stalls on it.
REQ-009 done  output  1  one-cycle pulse when HI/LO receive a new result.
REQ-010 hi  output  32  HI register, read by move-from-HI.
REQ-011 lo  output  32  LO register, read by move-from-LO.

Function
REQ-012 States SHALL be IDLE, MUL and DIV; busy SHALL be 1 exactly when state is not IDLE.
REQ-013 In IDLE, start=1 with ALUctrl=0x13 at edge k SHALL capture op_a/op_b, clear the iteration counter and enter MUL.
REQ-014 In IDLE, start=1 with any ALUctrl other than an enabled operation code SHALL be ignored: no state change and no done pulse.
REQ-015 MUL SHALL run one radix-2 shift-add step per cycle, for 32 steps on edges k+1..k+32; arithmetic SHALL be unsigned.
REQ-016 MUL width rule: the 64-bit product SHALL be exact; HI = product[63:32], LO = product[31:0].
REQ-017 On edge k+32, HI/LO SHALL be written, state SHALL return to IDLE, and done SHALL be 1 for the following cycle only.
REQ-018 busy SHALL be 1 for exactly 32 cycles per operation.
REQ-019 start while busy=1 SHALL be ignored; it is not queued.
REQ-020 On the done cycle, a new start SHALL be accepted with the same latency, giving back-to-back operations.
REQ-021 Flush in MUL/DIV SHALL return the block to IDLE on the next edge: HI/LO unchanged, no done pulse.
REQ-022 Flush in IDLE SHALL have no effect; flush SHALL take priority over a simultaneous start.
REQ-023 hi/lo SHALL change only on a done edge or on reset.
REQ-024 The iteration counter SHALL be 6 bits and terminate at 32; it SHALL NOT wrap.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0 and counter=0, including mid-operation; the first start SHALL be accepted on the first edge after rst_n deasserts.

Configuration
REQ-026 With macro HILO_MULTDIV_DIVU_EN defined, ALUctrl=0x14 with start in IDLE SHALL enter DIV: 32-step restoring unsigned divide, same latency and handshake as MUL, LO = quotient, HI = remainder.
REQ-027 With HILO_MULTDIV_DIVU_EN defined and op_b=0, the result SHALL be LO=0xFFFFFFFF, HI=op_a, with normal 32-cycle latency.
REQ-028 Without HILO_MULTDIV_DIVU_EN, the DIV state and divide datapath SHALL be absent, and 0x14 SHALL be treated per REQ-014.

Structure
REQ-029 The ALUctrl code constants (0x13, 0x14), the state encoding and the iteration count (32) SHALL reside in the shared ALU package, also used by the ALU controller.
REQ-030 The per-step datapath (conditional add / trial subtract and 64-bit shift) SHALL be one sub-module, multdiv_step; the FSM, counter and HI/LO registers SHALL stay in hilo_multdiv.

Verification
REQ-031 op_a=3, op_b=5, ALUctrl=0x13, start pulse -> busy for 32 cycles, then done pulse, HI=0x00000000, LO=0x0000000F.
REQ-032 op_a=op_b=0xFFFFFFFF, multiply -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 Multiply 2x2; second start with 7x7 at cycle 10 -> ignored: exactly one done pulse, LO=4; then a start on the done cycle -> LO=49 after 32 more cycles.
REQ-034 Prior HI/LO=0/4; start multiply; flush at cycle 10 -> busy=0 next cycle, no done pulse, HI/LO=0/4.
REQ-035 rst_n=0 mid-multiply -> busy, done, hi and lo = 0 immediately, without a clock edge.
REQ-036 With HILO_MULTDIV_DIVU_EN defined: 100/7 -> LO=14, HI=2; 9/0 -> LO=0xFFFFFFFF, HI=9. Without the macro: ALUctrl=0x14 -> busy stays 0.

Source files
------------

// File: rtl/hilo_multdiv_pkg.sv
// Shared ALU package: ALU-controller operation codes, HI/LO unit state encoding and iteration count.
// The divide code is only decoded by hilo_multdiv when HILO_MULTDIV_DIVU_EN is defined.
package hilo_multdiv_pkg;

  localparam logic [5:0] ALUCTRL_MULTU = 6'h13;
  localparam logic [5:0] ALUCTRL_DIVU  = 6'h14;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [5:0] ITER_COUNT = 6'd32;

  // An operation code is honoured only if its datapath is built into this configuration.
  function automatic logic is_enabled_op(input logic [5:0] code);
    logic en;
    en = (code == ALUCTRL_MULTU);
`ifdef HILO_MULTDIV_DIVU_EN
    en = en || (code == ALUCTRL_DIVU);
`endif
    return en;
  endfunction

endpackage

// File: rtl/hilo_multdiv_if.sv
// Request/result bundle between the pipeline (master) and the HI/LO multiply-divide unit (slave).
interface hilo_multdiv_if;

  logic        start;
  logic [5:0]  ALUctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, ALUctrl, op_a, op_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, ALUctrl, op_a, op_b, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/multdiv_step.sv
// One radix-2 iteration on the 64-bit working register: shift-add multiply step, and with
// HILO_MULTDIV_DIVU_EN a restoring-divide step (acc = remainder:quotient).
module multdiv_step (
`ifdef HILO_MULTDIV_DIVU_EN
  input  logic        is_div,
`endif
  input  logic [63:0] acc,
  input  logic [31:0] opd,
  output logic [63:0] nxt
);

  logic [32:0] sum_s;
  logic [63:0] mul_nxt_s;
`ifdef HILO_MULTDIV_DIVU_EN
  logic [32:0] rem_s;
  logic        ge_s;
  logic [31:0] diff_s;
`endif

  // Multiply: add multiplicand into the upper half when the LSB is set, then shift right with carry.
  always_comb begin
    sum_s     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'h0_0000_0000);
    mul_nxt_s = {sum_s, acc[31:1]};
  end

`ifdef HILO_MULTDIV_DIVU_EN
  // Divide: shift remainder left, trial-subtract divisor; a non-negative result sets the quotient bit.
  // A 33-bit remainder always exceeds the divisor, so the 32-bit difference is exact when ge_s is set.
  always_comb begin
    rem_s  = acc[63:31];
    ge_s   = (rem_s >= {1'b0, opd});
    diff_s = rem_s[31:0] - opd;
    if (is_div) begin
      if (ge_s) begin
        nxt = {diff_s, acc[30:0], 1'b1};
      end else begin
        nxt = {rem_s[31:0], acc[30:0], 1'b0};
      end
    end else begin
      nxt = mul_nxt_s;
    end
  end
`else
  // Multiply-only build: the step is the shift-add result.
  always_comb begin
    nxt = mul_nxt_s;
  end
`endif

endmodule

// File: rtl/hilo_multdiv.sv
// HI/LO iterative unsigned multiply (and, with HILO_MULTDIV_DIVU_EN, restoring divide) unit.
// FSM, iteration counter and HI/LO registers; per-step arithmetic lives in multdiv_step.
module hilo_multdiv
  import hilo_multdiv_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  hilo_multdiv_if.slave  bus
);

  logic [1:0]  state_r;
  logic [5:0]  cnt_r;
  logic [63:0] acc_r;
  logic [31:0] opd_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        done_r;
  logic        busy_r;

  logic [63:0] step_nxt_s;
  logic        accept_s;
  logic        last_step_s;
  logic        iterating_s;

  // Flush wins over a simultaneous start, so a flushed request is never launched.
  assign accept_s    = bus.start && !bus.flush && is_enabled_op(bus.ALUctrl);
  assign last_step_s = (cnt_r == (ITER_COUNT - 6'd1));
`ifdef HILO_MULTDIV_DIVU_EN
  assign iterating_s = (state_r == ST_MUL) || (state_r == ST_DIV);
`else
  assign iterating_s = (state_r == ST_MUL);
`endif

  multdiv_step u_step (
`ifdef HILO_MULTDIV_DIVU_EN
    .is_div (state_r == ST_DIV),
`endif
    .acc    (acc_r),
    .opd    (opd_r),
    .nxt    (step_nxt_s)
  );

  // Sequencer: launch, 32 iterations, HI/LO write-back with a one-cycle done pulse, or flush abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
      acc_r   <= 64'h0;
      opd_r   <= 32'h0;
      hi_r    <= 32'h0;
      lo_r    <= 32'h0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state_r == ST_IDLE) begin
        if (accept_s) begin
`ifdef HILO_MULTDIV_DIVU_EN
          state_r <= (bus.ALUctrl == ALUCTRL_DIVU) ? ST_DIV : ST_MUL;
`else
          state_r <= ST_MUL;
`endif
          busy_r  <= 1'b1;
          cnt_r   <= 6'd0;
          acc_r   <= {32'h0, bus.op_a};
          opd_r   <= bus.op_b;
        end else begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      end else if (iterating_s) begin
        if (bus.flush) begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end else begin
          acc_r <= step_nxt_s;
          // Counter stops at ITER_COUNT and is only cleared by the next launch.
          cnt_r <= cnt_r + 6'd1;
          if (last_step_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            hi_r    <= step_nxt_s[63:32];
            lo_r    <= step_nxt_s[31:0];
            done_r  <= 1'b1;
          end else begin
            state_r <= state_r;
            busy_r  <= 1'b1;
          end
        end
      end else begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_hilo_multdiv.sv
// Self-checking bench for hilo_multdiv against an arithmetic reference (optionally with HILO_MULTDIV_DIVU_EN).
module tb_hilo_multdiv;

  localparam logic [5:0] OP_MULTU = 6'h13;
  localparam logic [5:0] OP_DIVU  = 6'h14;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hilo_multdiv_if bus();

  hilo_multdiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa, wb;
    wa = {32'h0, a};
    wb = {32'h0, b};
    return wa * wb;
  endfunction

  // Returns {HI, LO} = {remainder, quotient}; divide by zero gives {a, all-ones}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic drive_idle();
    bus.start = 1'b0; bus.ALUctrl = 6'h00; bus.op_a = 32'h0; bus.op_b = 32'h0; bus.flush = 1'b0;
  endtask

  // Launch one request and watch 40 cycles; sample i=0 is the cycle after the launch edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] code,
                        output int bc, output int dc, output int da, output bit moved);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = bus.hi; l0 = bus.lo;
    bus.start = 1'b1; bus.ALUctrl = code; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom;
    bc = 0; dc = 0; da = -1; moved = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) bc++;
      if (bus.done) begin dc++; if (da < 0) da = i; end
      else if (dc == 0 && (bus.hi !== h0 || bus.lo !== l0)) moved = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
  endtask

  task automatic test_mul_basic();
    int bc, dc, da; bit mv;
    run_op(32'd3, 32'd5, OP_MULTU, bc, dc, da, mv);
    n_cmp++; if (bc !== 32) begin n_err++; $display("FAIL mul3x5_busy_cycles: got %0d want 32", bc); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL mul3x5_done_pulses: got %0d want 1", dc); end
    n_cmp++; if (da !== 32) begin n_err++; $display("FAIL mul3x5_done_cycle: got %0d want 32", da); end
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL mul3x5_hilo_early: got %b want 0", mv); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL mul3x5_hi: got %h want 00000000", bus.hi); end
    n_cmp++; if (bus.lo !== 32'hF) begin n_err++; $display("FAIL mul3x5_lo: got %h want 0000000f", bus.lo); end
  endtask

  task automatic test_mul_random();
    int bc, dc, da; bit mv;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int t = 0; t < 10; t++) begin
      case (t)
        0: begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        1: begin a = 32'h0;         b = $urandom;      end
        2: begin a = $urandom;      b = 32'h1;         end
        3: begin a = 32'h8000_0000; b = 32'h8000_0000; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      exp = ref_mul(a, b);
      run_op(a, b, OP_MULTU, bc, dc, da, mv);
      n_cmp++; if (bc !== 32 || dc !== 1 || da !== 32 || mv) begin
        n_err++; $display("FAIL mul_rand_handshake[%0d]: got busy=%0d done=%0d at=%0d early=%b want 32/1/32/0", t, bc, dc, da, mv);
      end
      n_cmp++; if ({bus.hi, bus.lo} !== exp) begin
        n_err++; $display("FAIL mul_rand_result[%0d] %h*%h: got %h_%h want %h", t, a, b, bus.hi, bus.lo, exp);
      end
    end
  endtask

  task automatic test_invalid_codes();
    logic [5:0]  code;
    logic [31:0] h0, l0;
    int bsy, dn;
    for (int t = 0; t < 8; t++) begin
      code = $urandom_range(0, 63);
`ifdef HILO_MULTDIV_DIVU_EN
      while (code == OP_MULTU || code == OP_DIVU) code = $urandom_range(0, 63);
`else
      if (t == 0) code = OP_DIVU;
      while (code == OP_MULTU) code = $urandom_range(0, 63);
`endif
      @(negedge clk);
      h0 = bus.hi; l0 = bus.lo;
      bus.start = 1'b1; bus.ALUctrl = code; bus.op_a = $urandom; bus.op_b = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
      bsy = 0; dn = 0;
      for (int i = 0; i < 5; i++) begin
        if (bus.busy) bsy++;
        if (bus.done) dn++;
        @(negedge clk);
      end
      n_cmp++; if (bsy !== 0 || dn !== 0) begin
        n_err++; $display("FAIL bad_code_ignored[%h]: got busy=%0d done=%0d want 0/0", code, bsy, dn);
      end
      n_cmp++; if (bus.hi !== h0 || bus.lo !== l0) begin
        n_err++; $display("FAIL bad_code_hilo[%h]: got %h_%h want %h_%h", code, bus.hi, bus.lo, h0, l0);
      end
    end
  endtask

  task automatic test_flush_idle();
    int bsy;
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.ALUctrl = OP_MULTU; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    bsy = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy) bsy++;
      @(negedge clk);
    end
    n_cmp++; if (bsy !== 0) begin n_err++; $display("FAIL flush_beats_start: got busy cycles %0d want 0", bsy); end
  endtask

  task automatic test_back_to_back();
    int da1, dc, bc;
    bit launched;
    logic [31:0] lo1;
    int d_at[$];
    @(negedge clk);
    bus.start = 1'b1; bus.ALUctrl = OP_MULTU; bus.op_a = 32'd2; bus.op_b = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    da1 = -1; dc = 0; bc = 0; launched = 1'b0; lo1 = 32'hDEAD_BEEF;
    for (int i = 0; i < 80; i++) begin
      if (bus.busy) bc++;
      if (i == 10 || (launched && i == da1 + 1)) bus.start = 1'b0;
      if (i == 9) begin bus.start = 1'b1; bus.op_a = 32'd7; bus.op_b = 32'd7; end
      if (bus.done) begin
        dc++; d_at.push_back(i);
        if (!launched) begin
          da1 = i; lo1 = bus.lo; launched = 1'b1;
          bus.start = 1'b1; bus.op_a = 32'd7; bus.op_b = 32'd7;
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_cmp++; if (da1 !== 32) begin n_err++; $display("FAIL b2b_first_done_cycle: got %0d want 32", da1); end
    n_cmp++; if (lo1 !== 32'd4) begin n_err++; $display("FAIL b2b_first_lo: got %0d want 4", lo1); end
    n_cmp++; if (dc !== 2) begin n_err++; $display("FAIL b2b_done_pulses: got %0d want 2", dc); end
    n_cmp++; if (d_at.size() != 2 || d_at[1] !== 65) begin
      n_err++; $display("FAIL b2b_second_done_cycle: got %0d entries last %0d want 65", d_at.size(), (d_at.size() > 0) ? d_at[$] : -1);
    end
    n_cmp++; if (bc !== 64) begin n_err++; $display("FAIL b2b_busy_cycles: got %0d want 64", bc); end
    n_cmp++; if (bus.lo !== 32'd49 || bus.hi !== 32'd0) begin n_err++; $display("FAIL b2b_second_result: got %h_%h want 0_31", bus.hi, bus.lo); end
  endtask

  task automatic test_flush();
    int bc, dc, da; bit mv;
    int dn;
    logic busy_before, busy_after;
    run_op(32'd2, 32'd2, OP_MULTU, bc, dc, da, mv);
    @(negedge clk);
    bus.start = 1'b1; bus.ALUctrl = OP_MULTU; bus.op_a = 32'd3; bus.op_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    dn = 0; busy_before = 1'b0; busy_after = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 9) begin busy_before = bus.busy; bus.flush = 1'b1; end
      if (i == 10) begin busy_after = bus.busy; bus.flush = 1'b0; end
      if (bus.done) dn++;
      @(negedge clk);
    end
    n_cmp++; if (busy_before !== 1'b1) begin n_err++; $display("FAIL flush_busy_before: got %b want 1", busy_before); end
    n_cmp++; if (busy_after !== 1'b0) begin n_err++; $display("FAIL flush_busy_after: got %b want 0", busy_after); end
    n_cmp++; if (dn !== 0) begin n_err++; $display("FAIL flush_no_done: got %0d pulses want 0", dn); end
    n_cmp++; if (bus.hi !== 32'd0 || bus.lo !== 32'd4) begin n_err++; $display("FAIL flush_hilo_kept: got %h_%h want 0_4", bus.hi, bus.lo); end
  endtask

  task automatic test_async_reset();
    int bc, dc, da; bit mv;
    bit seen;
    run_op(32'h1234_5678, 32'h9ABC_DEF1, OP_MULTU, bc, dc, da, mv);
    @(negedge clk);
    bus.start = 1'b1; bus.ALUctrl = OP_MULTU; bus.op_a = $urandom; bus.op_b = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy_before: got %b want 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL rst_async_ctrl: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
    n_cmp++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin n_err++; $display("FAIL rst_async_hilo: got %h_%h want 0_0", bus.hi, bus.lo); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1; bus.ALUctrl = OP_MULTU; bus.op_a = 32'd6; bus.op_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rst_first_start: got busy %b want 1", bus.busy); end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (!seen || bus.lo !== 32'd42) begin n_err++; $display("FAIL rst_first_result: got done=%b lo=%0d want 1/42", seen, bus.lo); end
  endtask

`ifdef HILO_MULTDIV_DIVU_EN
  task automatic test_div();
    int bc, dc, da; bit mv;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int t = 0; t < 8; t++) begin
      case (t)
        0: begin a = 32'd100;  b = 32'd7;  end
        1: begin a = 32'd9;    b = 32'd0;  end
        2: begin a = $urandom; b = 32'h0;  end
        3: begin a = 32'hFFFF_FFFF; b = 32'h1; end
        4: begin a = $urandom; b = $urandom_range(1, 255); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      exp = ref_div(a, b);
      run_op(a, b, OP_DIVU, bc, dc, da, mv);
      n_cmp++; if (bc !== 32 || dc !== 1 || da !== 32 || mv) begin
        n_err++; $display("FAIL div_handshake[%0d]: got busy=%0d done=%0d at=%0d early=%b want 32/1/32/0", t, bc, dc, da, mv);
      end
      n_cmp++; if ({bus.hi, bus.lo} !== exp) begin
        n_err++; $display("FAIL div_result[%0d] %h/%h: got hi=%h lo=%h want %h", t, a, b, bus.hi, bus.lo, exp);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_random();
    test_invalid_codes();
    test_flush_idle();
    test_back_to_back();
    test_flush();
`ifdef HILO_MULTDIV_DIVU_EN
    test_div();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
